// File: rtl/llc_mem_responder_pkg.sv
// Shared cache types for the LLC memory channel responder.
package llc_mem_responder_pkg;

  localparam int BITS_PER_LINE    = 128;
  localparam int LINE_ADDR_BITS   = 28;
  localparam int MEM_RSP_LAT_BITS = 8;

  typedef logic [BITS_PER_LINE-1:0]  line_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

endpackage

// File: rtl/llc_mem_responder_if.sv
// LLC memory request/response channel bundle.
interface llc_mem_responder_if
  import llc_mem_responder_pkg::*;
#(
  parameter int LINE_BITS = BITS_PER_LINE,
  parameter int ADDR_BITS = LINE_ADDR_BITS
);

  logic                 llc_mem_req_valid;
  logic                 llc_mem_req_ready;
  logic                 llc_mem_req_data_hwrite;
  logic [2:0]           llc_mem_req_data_hsize;
  logic [1:0]           llc_mem_req_data_hprot;
  logic [ADDR_BITS-1:0] llc_mem_req_data_addr;
  logic [LINE_BITS-1:0] llc_mem_req_data_line;
  logic                 llc_mem_rsp_valid;
  logic                 llc_mem_rsp_ready;
  logic [LINE_BITS-1:0] llc_mem_rsp_data_line;

  modport master (
    output llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
           llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
           llc_mem_rsp_ready,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line
  );

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
           llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
           llc_mem_rsp_ready,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line
  );

endinterface

// File: rtl/llc_mem_resp_store.sv
// Line store: one write port, one combinational read port, resettable valid bits.
module llc_mem_resp_store #(
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [LINE_BITS-1:0] rd_line
);

  localparam int DEPTH = 2 ** IDX_BITS;

  logic [LINE_BITS-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]     valid_r;

  // Valid bits: cleared by reset so the store reads back as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Data array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_line;
    end
  end

  assign rd_line = valid_r[rd_idx] ? mem_r[rd_idx] : '0;

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side responder: writes fill a line store, reads return after RD_LATENCY cycles.
module llc_mem_responder
  import llc_mem_responder_pkg::*;
#(
  parameter int LINE_BITS  = BITS_PER_LINE,
  parameter int ADDR_BITS  = LINE_ADDR_BITS,
  parameter int IDX_BITS   = 6,
  parameter int RD_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  llc_mem_responder_if.slave bus,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [MEM_RSP_LAT_BITS-1:0] LAT_LOAD = MEM_RSP_LAT_BITS'(RD_LATENCY - 1);

  logic [1:0]                  state_r, state_nxt_s;
  logic [MEM_RSP_LAT_BITS-1:0] cnt_r, cnt_nxt_s;
  logic                        rsp_valid_r, rsp_valid_nxt_s;
  logic [LINE_BITS-1:0]        rsp_line_r, rsp_line_nxt_s;
  logic                        req_fire_s, wr_fire_s, rd_done_s;
  logic [IDX_BITS-1:0]         idx_s;
  logic [LINE_BITS-1:0]        rd_line_s;
  logic                        unused_s;

  assign bus.llc_mem_req_ready     = (state_r == ST_IDLE);
  assign bus.llc_mem_rsp_valid     = rsp_valid_r;
  assign bus.llc_mem_rsp_data_line = rsp_line_r;

  assign req_fire_s = bus.llc_mem_req_valid && (state_r == ST_IDLE);
  assign wr_fire_s  = req_fire_s && bus.llc_mem_req_data_hwrite;
  assign idx_s      = bus.llc_mem_req_data_addr[IDX_BITS-1:0];
  // hsize/hprot and the aliased upper address bits have no effect.
  assign unused_s   = ^{bus.llc_mem_req_data_hsize, bus.llc_mem_req_data_hprot,
                        bus.llc_mem_req_data_addr[ADDR_BITS-1:IDX_BITS]};

  llc_mem_resp_store #(
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire_s),
    .wr_idx  (idx_s),
    .wr_line (bus.llc_mem_req_data_line),
    .rd_idx  (idx_s),
    .rd_line (rd_line_s)
  );

  // Next-state logic for the IDLE -> WAIT -> RSP read sequence.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_line_nxt_s  = rsp_line_r;
    rd_done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_fire_s && !bus.llc_mem_req_data_hwrite) begin
          state_nxt_s    = ST_WAIT;
          cnt_nxt_s      = LAT_LOAD;
          rsp_line_nxt_s = rd_line_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {MEM_RSP_LAT_BITS{1'b0}}) begin
          state_nxt_s     = ST_RSP;
          rsp_valid_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - {{(MEM_RSP_LAT_BITS-1){1'b0}}, 1'b1};
        end
      end
      ST_RSP: begin
        if (bus.llc_mem_rsp_ready) begin
          state_nxt_s     = ST_IDLE;
          rsp_valid_nxt_s = 1'b0;
          rd_done_s       = 1'b1;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM, latency counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_line_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_line_r  <= rsp_line_nxt_s;
    end
  end

  // Completed-read and accepted-write counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (rd_done_s) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (wr_fire_s) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/llc_mem_responder.md
Name: llc_mem_responder

Overview:
Memory-side responder for the LLC memory channel. It accepts line-granular memory requests on the llc_mem_req channel and returns read data on the llc_mem_rsp channel after a fixed, configurable latency. Writes update an internal line store and produce no response. It serves as the memory endpoint in LLC standalone benches and in small-memory FPGA configurations. It handles one outstanding read at a time.

Parameters:
LINE_BITS, 128, width of line_t (BITS_PER_LINE)
ADDR_BITS, 28, width of line_addr_t
IDX_BITS, 6, number of low line-address bits that index the store (2^IDX_BITS lines)
RD_LATENCY, 4, number of cycles from read acceptance to first rsp_valid; legal range 1..255

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
llc_mem_req_valid  in  1  request valid
llc_mem_req_ready  out  1  request ready
llc_mem_req_data_hwrite  in  1  1 = write, 0 = read
llc_mem_req_data_hsize  in  3  transfer size; ignored
llc_mem_req_data_hprot  in  2  protection bits; ignored
llc_mem_req_data_addr  in  ADDR_BITS  line address
llc_mem_req_data_line  in  LINE_BITS  write data
llc_mem_rsp_valid  out  1  read response valid
llc_mem_rsp_ready  in  1  response ready
llc_mem_rsp_data_line  out  LINE_BITS  read data
rd_cnt  out  32  completed read responses
wr_cnt  out  32  accepted writes

Behaviour:
Clocking and reset
- Single clock domain: clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, llc_mem_req_ready=1 (combinational from IDLE), llc_mem_rsp_valid=0, llc_mem_rsp_data_line=0, rd_cnt=0, wr_cnt=0, all store valid bits=0.
- The data array itself is not reset.

Addressing and store contents
- Index = addr[IDX_BITS-1:0]. Upper address bits are ignored, so addresses alias modulo 2^IDX_BITS.
- A read of a line whose valid bit is 0 returns all zeros.

Handshake
- A transfer occurs when valid && ready are high at the same rising edge.
- llc_mem_req_ready = (state==IDLE).
- Once llc_mem_rsp_valid is raised, it and llc_mem_rsp_data_line stay stable until the response handshake.

States
- IDLE
  - Write accepted: mem[idx] <= line, valid[idx] <= 1, wr_cnt++. Stay in IDLE, so back-to-back writes run at one per cycle.
  - Read accepted: snapshot data (mem[idx] if valid[idx], else 0) into the response register, load the latency counter, go to WAIT.
- WAIT
  - Counter runs down.
  - llc_mem_rsp_valid is first asserted exactly RD_LATENCY cycles after the acceptance edge. For RD_LATENCY=1, it is high in the cycle immediately following acceptance.
  - Enter RSP when the count expires.
- RSP
  - llc_mem_rsp_valid=1.
  - On handshake: rd_cnt++, rsp_valid drops at that edge, go to IDLE.
  - The next request can be accepted in the cycle after the handshake (ready is not combinationally fed from rsp_ready).

Boundary conditions
- Read data is captured at acceptance. Ordering is trivially preserved: no write can be accepted while a read is outstanding.
- rsp_ready held low: the block stays in RSP indefinitely with stable data.
- rsp_ready high before rsp_valid: no effect.
- rd_cnt and wr_cnt wrap modulo 2^32.
- rst asserted mid-operation: the pending read is discarded, no response is emitted, and the store is logically cleared (all valid bits reset).
- req_valid with hsize/hprot of any value: processed identically.

Decomposition:
- Shared cache package (cache_consts/cache_types): LINE_BITS/ADDR_BITS via the existing line_t and line_addr_t; add MEM_RSP_LAT_BITS=8.
- Local FSM enum {IDLE, WAIT, RSP} stays in the module.
- One natural sub-module: llc_mem_resp_store. It holds the 2^IDX_BITS x LINE_BITS array, has a 1-write/1-read combinational port, and keeps the async-reset valid-bit vector.

Test Plan:
- Read-after-reset: read addr 0x5 with RD_LATENCY=4, accepted at cycle 10 → rsp_valid first high at cycle 14, data=0, rd_cnt=1.
- Write then read: write addr 0x3 line=0xDEADBEEF_0123 → read addr 0x3 returns 0xDEADBEEF_0123. wr_cnt=1, req_ready stays 1 across the write.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid → rsp_valid and data stable throughout, req_ready=0. rsp_ready=1 → one handshake, req_ready=1 the next cycle.
- Aliasing: write 0x41 line=0xA, write 0x01 line=0xB (IDX_BITS=6) → read 0x41 returns 0xB.
- Reset mid-WAIT: read accepted, rst pulsed two cycles later → no rsp_valid ever; state IDLE; rd_cnt=0; a subsequent read of a previously written line returns 0.
- RD_LATENCY=1 with rsp_ready tied 1: alternate read/write stream → each read responds in the next cycle; counters match request counts exactly.
